prog_clock_divider: RTL and testbench

PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

---
 rtl/prog_clock_divider.sv | 120 ++++++++++++
 tb/tb_prog_clock_divider.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider: each channel emits a tick every D+1
// enabled cycles and a square wave of period 2*(D+1). Divisor updates land on a wrap.
module pcd_chan #(
  parameter int unsigned    CNT_W   = 25,
  parameter logic [CNT_W-1:0] DEF_DIV = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync_clear,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_data,
  output logic             tick,
  output logic             clk_out,
  output logic             upd_pending
);
  logic [CNT_W-1:0] cnt_q, cnt_d, act_q, act_d, pend_q, pend_d;
  logic             tick_q, tick_d, clk_q, clk_d, pv_q, pv_d;
  logic             wrap;

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    pend_d = pend_q;
    pv_d   = pv_q;
    tick_d = 1'b0;
    clk_d  = clk_q;
    wrap   = (cnt_q == act_q);
    if (sync_clear) begin
      cnt_d = '0;
      clk_d = 1'b0;
      if (pv_q) act_d = pend_q;
      pv_d  = 1'b0;
    end else if (!enable) begin
      // no period in flight while frozen, so a pending divisor can apply at once
      if (pv_q) begin
        act_d = pend_q;
        pv_d  = 1'b0;
      end
    end else begin
      cnt_d  = wrap ? '0 : cnt_q + 1'b1;
      tick_d = wrap;
      clk_d  = clk_q ^ wrap;
      if (wrap && pv_q) begin
        act_d = pend_q;
        pv_d  = 1'b0;
      end
    end
    // a write always lands in pending, even on a clear or wrap edge
    if (wr) begin
      pend_d = wr_data;
      pv_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      act_q  <= DEF_DIV;
      pend_q <= DEF_DIV;
      pv_q   <= 1'b0;
      tick_q <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      pv_q   <= pv_d;
      tick_q <= tick_d;
      clk_q  <= clk_d;
    end
  end

  assign tick        = tick_q;
  assign clk_out     = clk_q;
  assign upd_pending = pv_q;
endmodule

module prog_clock_divider #(
  parameter int unsigned      NUM_CH  = 3,
  parameter int unsigned      CNT_W   = 25,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'((64'd1 << (CNT_W-1)) - 64'd1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sync_clear,
  input  logic              div_wr,
  input  logic [2:0]        div_sel,
  input  logic [CNT_W-1:0]  div_data,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] upd_pending,
  output logic              wr_err
);
  logic wr_err_q, wr_err_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pcd_chan #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_ch (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .sync_clear  (sync_clear),
      .wr          (div_wr && (int'(div_sel) == i)),
      .wr_data     (div_data),
      .tick        (tick[i]),
      .clk_out     (clk_out[i]),
      .upd_pending (upd_pending[i])
    );
  end

  always_comb wr_err_d = div_wr && (int'(div_sel) >= int'(NUM_CH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_err_q <= 1'b0;
    else       wr_err_q <= wr_err_d;
  end

  assign wr_err = wr_err_q;
endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider at CNT_W=4, NUM_CH=3 (DEF_DIV = 7).
module tb_prog_clock_divider;
  logic       clk = 1'b0, reset = 1'b1, enable = 1'b0, sync_clear = 1'b0, div_wr = 1'b0;
  logic [2:0] div_sel = '0;
  logic [3:0] div_data = '0;
  logic [2:0] tick, clk_out, upd_pending;
  logic       wr_err;
  int         vecs = 0, errs = 0;

  prog_clock_divider #(.NUM_CH(3), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sync_clear(sync_clear),
    .div_wr(div_wr), .div_sel(div_sel), .div_data(div_data),
    .tick(tick), .clk_out(clk_out), .upd_pending(upd_pending), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, sc, wr;
    logic [2:0] sel;
    logic [3:0] data;
    logic [2:0] tk, ck, up;
    logic       er;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic en, input logic sc, input logic wr,
                      input logic [2:0] sel, input logic [3:0] data);
    enable = en; sync_clear = sc; div_wr = wr; div_sel = sel; div_data = data;
    @(posedge clk); #1;
    div_wr = 1'b0; sync_clear = 1'b0;
  endtask

  task automatic add(input logic en, input logic wr, input logic [2:0] sel, input logic [3:0] data,
                     input logic [2:0] tk, input logic [2:0] ck, input logic [2:0] up, input logic er);
    tbl.push_back('{en, 1'b0, wr, sel, data, tk, ck, up, er});
  endtask

  initial begin
    // load ch0 D=3 while frozen, bad-select write, then run 16 enabled edges
    add(0,1,0,3, 3'b000,3'b000,3'b001,0);
    add(0,0,0,0, 3'b000,3'b000,3'b000,0);
    add(0,1,5,9, 3'b000,3'b000,3'b000,1);
    add(0,0,0,0, 3'b000,3'b000,3'b000,0);
    for (int n = 1; n <= 3; n++) add(1,0,0,0, 3'b000,3'b000,3'b000,0);
    add(1,0,0,0, 3'b001,3'b001,3'b000,0);
    add(0,0,0,0, 3'b000,3'b001,3'b000,0);
    add(0,0,0,0, 3'b000,3'b001,3'b000,0);
    for (int n = 5; n <= 7; n++) add(1,0,0,0, 3'b000,3'b001,3'b000,0);
    add(1,0,0,0, 3'b111,3'b110,3'b000,0);
    for (int n = 9; n <= 11; n++) add(1,0,0,0, 3'b000,3'b110,3'b000,0);
    add(1,0,0,0, 3'b001,3'b111,3'b000,0);
    for (int n = 13; n <= 15; n++) add(1,0,0,0, 3'b000,3'b111,3'b000,0);
    add(1,0,0,0, 3'b111,3'b000,3'b000,0);

    @(posedge clk); @(posedge clk); #1;
    chk("rst_tick", tick, 3'b000);
    chk("rst_clk", clk_out, 3'b000);
    chk("rst_upd", upd_pending, 3'b000);
    chk("rst_err", wr_err, 1'b0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].sc, tbl[i].wr, tbl[i].sel, tbl[i].data);
      chk($sformatf("tbl%0d_tick", i), tick, tbl[i].tk);
      chk($sformatf("tbl%0d_clk", i), clk_out, tbl[i].ck);
      chk($sformatf("tbl%0d_upd", i), upd_pending, tbl[i].up);
      chk($sformatf("tbl%0d_err", i), wr_err, tbl[i].er);
    end

    // ch1 D=5, ch2 D=0 loaded while frozen
    step(0,0,1,1,5); chk("ld1_upd", upd_pending, 3'b010);
    step(0,0,1,2,0); chk("ld2_upd", upd_pending, 3'b100);
    step(0,0,0,0,0); chk("ld3_upd", upd_pending, 3'b000);

    // ch1 rewritten to D=1 while cnt=2: one more 6-cycle period, then every 2
    for (int n = 1; n <= 12; n++) begin
      logic t0, t1, c0, c1, c2;
      step(1,0,(n == 3),1,1);
      t0 = (n % 4 == 0);
      t1 = (n >= 6) && (n % 2 == 0);
      c0 = ((n / 4) % 2 == 1);
      c1 = (n >= 6) && (((n - 6) / 2) % 2 == 0);
      c2 = (n % 2 == 1);
      chk($sformatf("upd_n%0d_tick", n), tick, {1'b1, t1, t0});
      chk($sformatf("upd_n%0d_clk", n), clk_out, {c2, c1, c0});
      chk($sformatf("upd_n%0d_upd", n), upd_pending, {1'b0, (n >= 3 && n <= 5), 1'b0});
    end

    for (int k = 0; k < 3; k++) begin
      step(0,0,0,0,0);
      chk($sformatf("frz%0d_tick", k), tick, 3'b000);
      chk($sformatf("frz%0d_clk", k), clk_out, 3'b001);
    end
    step(1,0,0,0,0);
    chk("resume_tick", tick, 3'b100);
    chk("resume_clk", clk_out, 3'b101);

    // pending ch0 D=2, then sync_clear on a wrap edge with a coincident ch1 write
    step(1,0,1,0,2);
    chk("pre14_tick", tick, 3'b110); chk("pre14_clk", clk_out, 3'b011); chk("pre14_upd", upd_pending, 3'b001);
    step(1,0,0,0,0);
    chk("pre15_tick", tick, 3'b100); chk("pre15_clk", clk_out, 3'b111); chk("pre15_upd", upd_pending, 3'b001);
    step(1,1,1,1,4);
    chk("sc_tick", tick, 3'b000); chk("sc_clk", clk_out, 3'b000); chk("sc_upd", upd_pending, 3'b010);
    for (int k = 1; k <= 7; k++) begin
      step(1,0,0,0,0);
      chk($sformatf("psc%0d_tick", k), tick, {1'b1, (k == 2 || k == 7), (k % 3 == 0)});
      chk($sformatf("psc%0d_upd", k), upd_pending, (k < 2) ? 3'b010 : 3'b000);
    end
    chk("psc7_clk", clk_out, 3'b100);

    // asynchronous reset between edges with a write pending
    step(1,0,1,0,1);
    chk("prerst_upd", upd_pending, 3'b001);
    #3 reset = 1'b1;
    #1;
    chk("arst_tick", tick, 3'b000);
    chk("arst_clk", clk_out, 3'b000);
    chk("arst_upd", upd_pending, 3'b000);
    chk("arst_err", wr_err, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ch1 at full range D=15; ch0/ch2 back on DEF_DIV=7
    step(0,0,1,1,15); chk("max_ld_upd", upd_pending, 3'b010);
    step(0,0,0,0,0);  chk("max_ap_upd", upd_pending, 3'b000);
    for (int k = 1; k <= 32; k++) begin
      logic t8, t16, c8, c16;
      step(1,0,0,0,0);
      t8 = (k % 8 == 0); t16 = (k % 16 == 0);
      c8 = ((k / 8) % 2 == 1); c16 = ((k / 16) % 2 == 1);
      chk($sformatf("max%0d_tick", k), tick, {t8, t16, t8});
      chk($sformatf("max%0d_clk", k), clk_out, {c8, c16, c8});
      chk($sformatf("max%0d_upd", k), upd_pending, 3'b000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
